piso_tx_sched: RTL and testbench
================================

# piso_tx_sched

Round-robin transmit scheduler that shares one 8-bit parallel-to-serial shift datapath among `NUM_REQ` byte producers. It accepts one byte per valid/ready handshake from the granted requester, loads it, and shifts it out LSB-first over `DATA_W` cycles with framing strobes. It sits between the byte-producing blocks and the single serial output pin, and it owns the shift register.

## Interface
- `NUM_REQ`, 4: number of requesters (2..8).
- `DATA_W`, 8: byte width and serial frame length in bits.
- `GAP_CYCLES`, 0: idle cycles inserted after each frame (0..15).
- `ID_W`, `$clog2(NUM_REQ)`: requester index width (derived).

- `clk`  in  1  single clock; all state changes on rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `req_valid`  in  NUM_REQ  per-requester byte available.
- `req_data`  in  NUM_REQ*DATA_W  requester i byte at `[i*DATA_W +: DATA_W]`.
- `req_ready`  out  NUM_REQ  one-hot grant; a transfer occurs when `req_valid[i] && req_ready[i]`.
- `ser_data`  out  1  serial bit, LSB first.
- `ser_valid`  out  1  `ser_data` is a frame bit this cycle.
- `ser_last`  out  1  final bit of the frame.
- `ser_id`  out  ID_W  index of the requester whose byte is being shifted.
- `busy`  out  1  high in SHIFT or GAP.
- `frame_cnt`  out  16  completed frames, wraps 0xFFFF→0.

## Operation
- States: IDLE, SHIFT, GAP.
- IDLE: if any `req_valid`, the round-robin winner gets `req_ready` (combinational, same cycle). The search starts at `last_grant+1` modulo NUM_REQ. The handshake loads `shreg` with the winner's byte, loads `ser_id` with the winner index, sets `bit_cnt`=0, updates `last_grant`, and goes to SHIFT. With no valid input the state stays IDLE and `req_ready`=0.
- `req_ready` is 0 in every state other than IDLE. At most one bit is set.
- SHIFT: `ser_data`=`shreg[0]`, `ser_valid`=1, `ser_last`=(`bit_cnt`==DATA_W-1). Each cycle `shreg` shifts right with 0 fill and `bit_cnt` increments.
- On the cycle with `ser_last`, `frame_cnt` increments. The next state is GAP if GAP_CYCLES>0, otherwise IDLE.
- GAP: `gap_cnt` counts GAP_CYCLES cycles, then the state goes to IDLE. All `ser_*` strobes are 0.
- Outside SHIFT, `ser_data`, `ser_valid` and `ser_last` are 0. `ser_id` holds its last value.
- Requester rule: once `req_valid` is raised it stays high with stable data until accepted. The bench checks this rule; the block does not check it.

## Timing
- Reset values: `req_ready`=0, `ser_data`=0, `ser_valid`=0, `ser_last`=0, `ser_id`=0, `busy`=0, `frame_cnt`=0, state=IDLE, `last_grant`=NUM_REQ-1 (so requester 0 wins first).
- Latency: handshake at cycle T. Bit 0 is on `ser_data` at T+1, bit DATA_W-1 with `ser_last` at T+DATA_W.
- Frame spacing: the earliest next handshake is T+DATA_W+1+GAP_CYCLES. The period is DATA_W+1+GAP_CYCLES cycles per byte at full load.
- Simultaneous requests: the grant goes to the first valid requester after `last_grant`. A single persistent requester is re-granted every frame.
- A `req_valid` that rises while busy is served only after the block returns to IDLE.
- Reset mid-frame: all outputs clear immediately (asynchronously). The frame is abandoned with no `ser_last`, `frame_cnt` does not increment, and `last_grant` returns to NUM_REQ-1.
- `frame_cnt` wrap: 0xFFFF plus one frame gives 0x0000, with no flag.

## Structure
- Shared package `piso_ctrl_pkg` holds:
  - the state enum (IDLE/SHIFT/GAP);
  - `PISO_DATA_W`=8;
  - the `frame_cnt` width constant.
- Sub-module `rr_arbiter`: parameter NUM_REQ. Inputs are the request vector, `last_grant` and an enable. Outputs are the one-hot grant and the winner index. It is purely combinational.
- The top level holds the FSM, `shreg`, `bit_cnt`, `gap_cnt`, `last_grant` and `frame_cnt`.

## Test plan
- Single byte: after reset, `req_valid[0]`=1 with data 0xA5 → handshake at T. `ser_data` then reads 1,0,1,0,0,1,0,1 over T+1..T+8, `ser_last` is high only at T+8, `ser_id`=0, and `frame_cnt`=1.
- Round robin, all four requesters always valid (0x11,0x22,0x33,0x44), GAP=0 → grants in order 0,1,2,3,0. Handshakes are 9 cycles apart.
- Contention with priority: requesters 1 and 3 valid after a grant to 1 → 3 is served next, then 1.
- Gap: GAP_CYCLES=3, requester 2 always valid → handshakes 12 cycles apart, with `busy`=1 and `ser_valid`=0 during the 3 gap cycles.
- Reset mid-frame: assert `rst` after bit 3 of 0xFF → outputs are 0 in the same cycle, `frame_cnt` stays 0, and requester 0 wins the first grant after reset.
- Counter wrap: force 65 536 frames (or preload `frame_cnt` via a bench hook) → 0xFFFF then 0x0000.

Source files
------------

// File: rtl/piso_ctrl_pkg.sv
// Shared types and constants for the PISO transmit scheduler.
package piso_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_GAP   = 2'd2
    } state_t;

    localparam int PISO_DATA_W = 8;
    localparam int FRAME_CNT_W = 16;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: search starts one past last_grant and
// wraps, so the most recently served requester has the lowest priority.
module rr_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int ID_W    = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [ID_W-1:0]    last_grant,
    input  logic               en,
    output logic [NUM_REQ-1:0] grant,
    output logic [ID_W-1:0]    grant_id
);

    logic found;
    int   idx;

    always_comb begin
        grant    = '0;
        grant_id = '0;
        found    = 1'b0;
        idx      = 0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            idx = int'(last_grant) + k;
            if (idx >= NUM_REQ) idx = idx - NUM_REQ;
            if (en && !found && req[ID_W'(idx)]) begin
                found               = 1'b1;
                grant[ID_W'(idx)]   = 1'b1;
                grant_id            = ID_W'(idx);
            end
        end
    end

endmodule

// File: rtl/piso_tx_sched.sv
// Round-robin byte scheduler feeding a single LSB-first serial shifter, with
// optional idle gap after each frame and a wrapping completed-frame counter.
module piso_tx_sched
    import piso_ctrl_pkg::*;
#(
    parameter int NUM_REQ    = 4,
    parameter int DATA_W     = PISO_DATA_W,
    parameter int GAP_CYCLES = 0,
    parameter int ID_W       = $clog2(NUM_REQ),
    parameter logic [FRAME_CNT_W-1:0] FRAME_CNT_INIT = '0
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [NUM_REQ-1:0]        req_valid,
    input  logic [NUM_REQ*DATA_W-1:0] req_data,
    output logic [NUM_REQ-1:0]        req_ready,
    output logic                      ser_data,
    output logic                      ser_valid,
    output logic                      ser_last,
    output logic [ID_W-1:0]           ser_id,
    output logic                      busy,
    output logic [FRAME_CNT_W-1:0]    frame_cnt
);

    localparam int BC_W  = $clog2(DATA_W);
    localparam int GAP_W = 4;

    state_t              state, state_nxt;
    logic [DATA_W-1:0]   shreg;
    logic [BC_W-1:0]     bit_cnt;
    logic [GAP_W-1:0]    gap_cnt;
    logic [ID_W-1:0]     last_grant;
    logic [ID_W-1:0]     win_id;
    logic [NUM_REQ-1:0]  grant;
    logic                hs;
    logic                frame_end;
    logic                gap_end;

    // Gating with rst keeps req_ready low while reset is held.
    rr_arbiter #(
        .NUM_REQ (NUM_REQ),
        .ID_W    (ID_W)
    ) u_arb (
        .req        (req_valid),
        .last_grant (last_grant),
        .en         (state == ST_IDLE && !rst),
        .grant      (grant),
        .grant_id   (win_id)
    );

    assign req_ready = grant;
    assign hs        = |(req_valid & grant);
    assign frame_end = (state == ST_SHIFT) && (bit_cnt == BC_W'(DATA_W - 1));
    assign gap_end   = (state == ST_GAP) && (gap_cnt == GAP_W'(GAP_CYCLES - 1));

    assign ser_valid = (state == ST_SHIFT);
    assign ser_data  = (state == ST_SHIFT) && shreg[0];
    assign ser_last  = frame_end;
    assign busy      = (state != ST_IDLE);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= ST_IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE:  if (hs) state_nxt = ST_SHIFT;
            ST_SHIFT: if (frame_end) state_nxt = (GAP_CYCLES > 0) ? ST_GAP : ST_IDLE;
            ST_GAP:   if (gap_end) state_nxt = ST_IDLE;
            default:  state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            shreg      <= '0;
            bit_cnt    <= '0;
            ser_id     <= '0;
            last_grant <= ID_W'(NUM_REQ - 1);
        end else if (hs) begin
            shreg      <= req_data[win_id*DATA_W +: DATA_W];
            bit_cnt    <= '0;
            ser_id     <= win_id;
            last_grant <= win_id;
        end else if (state == ST_SHIFT) begin
            shreg      <= shreg >> 1;
            bit_cnt    <= bit_cnt + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            gap_cnt   <= '0;
            frame_cnt <= FRAME_CNT_INIT;
        end else begin
            if (frame_end)             gap_cnt <= '0;
            else if (state == ST_GAP)  gap_cnt <= gap_cnt + 1'b1;
            if (frame_end) frame_cnt <= frame_cnt + 1'b1;
        end
    end

endmodule

// File: tb/tb_piso_tx_sched.sv
// Scoreboard bench: two schedulers (no gap / 3-cycle gap with counter preset
// near wrap) driven by directed and random requesters against a timeline model.
module tb_piso_tx_sched;

    localparam int N  = 4;
    localparam int DW = 8;

    typedef struct packed {
        logic [3:0]  ready;
        logic        busy;
        logic        sv;
        logic        sd;
        logic        sl;
        logic [1:0]  id;
        logic [15:0] fc;
    } rec_t;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic [N-1:0]    req_valid_s [2];
    logic [N*DW-1:0] req_data_s  [2];
    logic [N-1:0]    req_ready_s [2];
    logic            ser_data_s  [2];
    logic            ser_valid_s [2];
    logic            ser_last_s  [2];
    logic [1:0]      ser_id_s    [2];
    logic            busy_s      [2];
    logic [15:0]     frame_cnt_s [2];

    for (genvar g = 0; g < 2; g++) begin : g_dut
        piso_tx_sched #(
            .NUM_REQ        (N),
            .DATA_W         (DW),
            .GAP_CYCLES     ((g == 0) ? 0 : 3),
            .FRAME_CNT_INIT ((g == 0) ? 16'h0000 : 16'hFFFD)
        ) u_dut (
            .clk       (clk),
            .rst       (rst),
            .req_valid (req_valid_s[g]),
            .req_data  (req_data_s[g]),
            .req_ready (req_ready_s[g]),
            .ser_data  (ser_data_s[g]),
            .ser_valid (ser_valid_s[g]),
            .ser_last  (ser_last_s[g]),
            .ser_id    (ser_id_s[g]),
            .busy      (busy_s[g]),
            .frame_cnt (frame_cnt_s[g])
        );
    end

    // Reference model state
    int         free_at [2];
    int         last_g  [2];
    int         hs_cyc  [2];
    int         cur_id  [2];
    int         fcnt    [2];
    logic [7:0] hs_dat  [2];
    logic [N-1:0] pv    [2];
    logic [7:0] pd      [2][N];
    logic       rst_next;
    int         cyc;
    bit         done;
    rec_t       q0[$];
    rec_t       q1[$];

    int n_total = 0;
    int n_pass  = 0;
    int mcyc    = 0;
    bit saw_ffff = 1'b0;
    bit saw_wrap = 1'b0;

    function automatic int gap_of(input int g);
        return (g == 0) ? 0 : 3;
    endfunction

    function automatic int init_of(input int g);
        return (g == 0) ? 0 : 32'hFFFD;
    endfunction

    task automatic tick();
        rec_t r;
        int   k;
        int   w;
        @(posedge clk);
        #1;
        rst = rst_next;
        if (rst_next) begin
            pv[0] = '0;
            pv[1] = '0;
        end
        for (int g = 0; g < 2; g++) begin
            req_valid_s[g] = pv[g];
            for (int i = 0; i < N; i++) req_data_s[g][i*DW +: DW] = pd[g][i];
        end
        for (int g = 0; g < 2; g++) begin
            r = '0;
            if (rst_next) begin
                free_at[g] = 0;
                last_g[g]  = N - 1;
                hs_cyc[g]  = -100;
                cur_id[g]  = 0;
                fcnt[g]    = init_of(g);
                r.fc       = 16'(fcnt[g]);
            end else begin
                k      = cyc - hs_cyc[g] - 1;
                r.id   = 2'(cur_id[g]);
                r.fc   = 16'(fcnt[g]);
                r.busy = (cyc < free_at[g]);
                if (k >= 0 && k < DW) begin
                    r.sv = 1'b1;
                    r.sd = hs_dat[g][k[2:0]];
                    r.sl = (k == DW - 1);
                end
                if (r.sl) fcnt[g] = (fcnt[g] + 1) % 65536;
                if (!r.busy && pv[g] != '0) begin
                    w = 0;
                    for (int j = 1; j <= N; j++) begin
                        w = (last_g[g] + j) % N;
                        if (pv[g][w[1:0]]) break;
                    end
                    r.ready[w[1:0]] = 1'b1;
                    hs_cyc[g]  = cyc;
                    hs_dat[g]  = pd[g][w[1:0]];
                    cur_id[g]  = w;
                    last_g[g]  = w;
                    free_at[g] = cyc + DW + 1 + gap_of(g);
                    pv[g][w[1:0]] = 1'b0;
                end
            end
            if (g == 0) q0.push_back(r);
            else        q1.push_back(r);
        end
        cyc++;
    endtask

    task automatic drain();
        for (int t = 0; t < 80 && (pv[0] != '0 || pv[1] != '0 ||
                                   cyc < free_at[0] || cyc < free_at[1]); t++)
            tick();
    endtask

    task automatic chk(input string nm, input int g, input int act, input int exp);
        n_total++;
        if (act == exp) n_pass++;
        else $display("FAIL %s dut%0d cycle %0d: got %0h expected %0h", nm, g, mcyc, act, exp);
    endtask

    // Monitor: pops one expected record per DUT per cycle and compares.
    initial begin
        rec_t e;
        forever begin
            @(negedge clk);
            for (int g = 0; g < 2; g++) begin
                if ((g == 0 ? q0.size() : q1.size()) == 0) begin
                    chk("queue_underflow", g, 0, 1);
                end else begin
                    e = (g == 0) ? q0.pop_front() : q1.pop_front();
                    chk("req_ready", g, int'(req_ready_s[g]), int'(e.ready));
                    chk("busy",      g, int'(busy_s[g]),      int'(e.busy));
                    chk("ser_valid", g, int'(ser_valid_s[g]), int'(e.sv));
                    chk("ser_data",  g, int'(ser_data_s[g]),  int'(e.sd));
                    chk("ser_last",  g, int'(ser_last_s[g]),  int'(e.sl));
                    chk("ser_id",    g, int'(ser_id_s[g]),    int'(e.id));
                    chk("frame_cnt", g, int'(frame_cnt_s[g]), int'(e.fc));
                end
            end
            if (!rst) begin
                if (frame_cnt_s[1] == 16'hFFFF) saw_ffff = 1'b1;
                else if (saw_ffff && frame_cnt_s[1] == 16'h0000) saw_wrap = 1'b1;
            end
            mcyc++;
            if (done) begin
                chk("frame_cnt_wrap_seen", 1, int'(saw_wrap), 1);
                $display("%0d/%0d checks passed", n_pass, n_total);
                $finish;
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: bench did not finish");
        $fatal(1);
    end

    // Stimulus
    initial begin
        rst      = 1'b1;
        rst_next = 1'b1;
        cyc      = 0;
        done     = 1'b0;
        for (int g = 0; g < 2; g++) begin
            pv[g]          = '0;
            req_valid_s[g] = '0;
            req_data_s[g]  = '0;
            free_at[g]     = 0;
            last_g[g]      = N - 1;
            hs_cyc[g]      = -100;
            cur_id[g]      = 0;
            fcnt[g]        = init_of(g);
            hs_dat[g]      = '0;
            for (int i = 0; i < N; i++) pd[g][i] = '0;
        end

        repeat (3) tick();
        rst_next = 1'b0;

        // single byte 0xA5 from requester 0
        pv[0][0] = 1'b1; pd[0][0] = 8'hA5;
        pv[1][2] = 1'b1; pd[1][2] = 8'h5A;
        repeat (14) tick();

        // all four persistently valid; dut1 requester 2 persistently valid
        repeat (50) begin
            for (int i = 0; i < N; i++)
                if (!pv[0][i]) begin pv[0][i] = 1'b1; pd[0][i] = 8'(17 * (i + 1)); end
            if (!pv[1][2]) begin pv[1][2] = 1'b1; pd[1][2] = 8'($urandom); end
            tick();
        end
        drain();

        // contention between requesters 1 and 3
        repeat (60) begin
            for (int g = 0; g < 2; g++) begin
                if (!pv[g][1]) begin pv[g][1] = 1'b1; pd[g][1] = 8'($urandom); end
                if (!pv[g][3]) begin pv[g][3] = 1'b1; pd[g][3] = 8'($urandom); end
            end
            tick();
        end
        drain();

        // reset after bit 3 of 0xFF
        pv[0][0] = 1'b1; pd[0][0] = 8'hFF;
        tick();
        repeat (4) tick();
        rst_next = 1'b1;
        repeat (2) tick();
        rst_next = 1'b0;
        pv[0][0] = 1'b1; pd[0][0] = 8'($urandom);
        pv[0][2] = 1'b1; pd[0][2] = 8'($urandom);
        repeat (30) tick();
        drain();

        // random traffic; dut1 counter passes through the wrap
        repeat (700) begin
            for (int g = 0; g < 2; g++)
                for (int i = 0; i < N; i++)
                    if (!pv[g][i] && $urandom_range(0, 7) == 0) begin
                        pv[g][i] = 1'b1;
                        pd[g][i] = 8'($urandom);
                    end
            tick();
        end
        done = 1'b1;
    end

endmodule
